// File: rtl/note_lookahead_buffer_pkg.sv
// Shared constants for the note lookahead buffer and its display consumer.
// Field offsets describe the {past,current,future} buffer word.
package note_lookahead_buffer_pkg;

    localparam int NOTE_W          = 6;
    localparam int LOOKAHEAD_DEPTH = 4;
    localparam int NOTE_REST       = 0;

    localparam int FUTURE_LSB  = 0;
    localparam int CURRENT_LSB = NOTE_W;
    localparam int PAST_LSB    = 2 * NOTE_W;
    localparam int BUF_W       = 3 * NOTE_W;

    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/note_fifo.sv
// Synchronous lookahead FIFO; count is the only full/empty source.
// Pointers wrap naturally because DEPTH is a power of two.
module note_fifo
    import note_lookahead_buffer_pkg::*;
#(
    parameter int WIDTH = NOTE_W,
    parameter int DEPTH = LOOKAHEAD_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = count_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/note_lookahead_buffer.sv
// Past/current/future note window fed by a lookahead FIFO, shadowed
// into a frame-stable buffer that only loads while vsync is low.
module note_lookahead_buffer #(
    parameter int NOTE_W = note_lookahead_buffer_pkg::NOTE_W,
    parameter int DEPTH  = note_lookahead_buffer_pkg::LOOKAHEAD_DEPTH,
    localparam int CW = note_lookahead_buffer_pkg::count_w(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [NOTE_W-1:0]   in_note,
    output logic                in_ready,
    input  logic                advance,
    input  logic                vsync,
    output logic [3*NOTE_W-1:0] buffer,
    output logic                frame_update,
    output logic [CW-1:0]       count,
    output logic                underrun
);

    import note_lookahead_buffer_pkg::NOTE_REST;

    localparam logic [NOTE_W-1:0] REST = NOTE_W'(NOTE_REST);

    logic                push, pop, full, empty;
    logic [NOTE_W-1:0]   head, future;
    logic [NOTE_W-1:0]   past_q, past_d;
    logic [NOTE_W-1:0]   current_q, current_d;
    logic                underrun_q, underrun_d;
    logic [3*NOTE_W-1:0] live;
    logic [3*NOTE_W-1:0] buffer_q, buffer_d;
    logic                frame_update_q, frame_update_d;

    // in_ready depends only on the registered count, never on advance
    assign in_ready = ~full;
    assign push     = in_valid & in_ready;
    assign pop      = advance & ~empty;
    assign future   = empty ? REST : head;
    assign live     = {past_q, current_q, future};

    note_fifo #(
        .WIDTH (NOTE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .pop   (pop),
        .din   (in_note),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        past_d         = past_q;
        current_d      = current_q;
        underrun_d     = underrun_q;
        buffer_d       = buffer_q;
        frame_update_d = 1'b0;
        if (advance) begin
            past_d    = current_q;
            current_d = future;
            if (empty) begin
                underrun_d = 1'b1;
            end
        end
        if (!vsync) begin
            buffer_d       = live;
            frame_update_d = (live != buffer_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            past_q         <= REST;
            current_q      <= REST;
            underrun_q     <= 1'b0;
            buffer_q       <= '0;
            frame_update_q <= 1'b0;
        end else begin
            past_q         <= past_d;
            current_q      <= current_d;
            underrun_q     <= underrun_d;
            buffer_q       <= buffer_d;
            frame_update_q <= frame_update_d;
        end
    end

    assign buffer       = buffer_q;
    assign frame_update = frame_update_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_note_lookahead_buffer.sv
// Scoreboard bench for note_lookahead_buffer: directed scenarios
// followed by a long random run against a queue-based window model.
module tb_note_lookahead_buffer;
    import note_lookahead_buffer_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [NOTE_W-1:0] in_note;
    logic              in_ready;
    logic              advance;
    logic              vsync;
    logic [BUF_W-1:0]  buffer;
    logic              frame_update;
    logic [2:0]        count;
    logic              underrun;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [BUF_W-1:0] bv;
        logic             fu;
        logic [2:0]       cnt;
        logic             rdy;
        logic             und;
    } exp_t;

    exp_t              sb[$];
    logic [NOTE_W-1:0] mq[$];
    logic [NOTE_W-1:0] m_past, m_cur;
    logic              m_under;
    logic [BUF_W-1:0]  m_buf;

    always #5 clk = ~clk;

    note_lookahead_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_note      (in_note),
        .in_ready     (in_ready),
        .advance      (advance),
        .vsync        (vsync),
        .buffer       (buffer),
        .frame_update (frame_update),
        .count        (count),
        .underrun     (underrun)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BUF_W-1:0] win(input logic [NOTE_W-1:0] p,
                                             input logic [NOTE_W-1:0] c,
                                             input logic [NOTE_W-1:0] f);
        logic [BUF_W-1:0] w;
        w = (BUF_W'(p) << PAST_LSB) | (BUF_W'(c) << CURRENT_LSB)
          | (BUF_W'(f) << FUTURE_LSB);
        return w;
    endfunction

    task automatic model_reset();
        mq.delete();
        sb.delete();
        m_past  = '0;
        m_cur   = '0;
        m_under = 1'b0;
        m_buf   = '0;
    endtask

    task automatic model_edge(input logic v, input logic [NOTE_W-1:0] n,
                              input logic adv, input logic vs);
        exp_t              e;
        logic [NOTE_W-1:0] fut;
        logic [BUF_W-1:0]  lv;
        logic              rdy;
        fut  = (mq.size() > 0) ? mq[0] : '0;
        lv   = win(m_past, m_cur, fut);
        rdy  = (mq.size() != 4);
        e.fu = !vs && (lv != m_buf);
        if (!vs) m_buf = lv;
        if (adv) begin
            m_past = m_cur;
            m_cur  = fut;
            if (mq.size() > 0) mq.delete(0);
            else m_under = 1'b1;
        end
        if (v && rdy) mq.push_back(n);
        e.bv  = m_buf;
        e.cnt = 3'(mq.size());
        e.rdy = (mq.size() != 4);
        e.und = m_under;
        sb.push_back(e);
    endtask

    task automatic step(input logic v, input logic [NOTE_W-1:0] n,
                        input logic adv, input logic vs);
        exp_t e;
        in_valid = v;
        in_note  = n;
        advance  = adv;
        vsync    = vs;
        model_edge(v, n, adv, vs);
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("buffer", buffer, e.bv);
            check("frame_update", frame_update, e.fu);
            check("count", count, e.cnt);
            check("in_ready", in_ready, e.rdy);
            check("underrun", underrun, e.und);
        end
    endtask

    task automatic hit_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_buffer", buffer, 0);
        check("rst_count", count, 0);
        check("rst_underrun", underrun, 0);
        check("rst_fu", frame_update, 0);
        model_reset();
        in_valid = 1'b0;
        advance  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1 check("rst_in_ready", in_ready, 1);
        @(negedge clk);
    endtask

    initial begin
        logic vs_r;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_note  = '0;
        advance  = 1'b0;
        vsync    = 1'b0;
        model_reset();
        #1;
        check("init_buffer", buffer, 0);
        check("init_count", count, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // reset mid-stream with count=3 and a non-zero buffer
        step(1, 6'd5, 0, 0);
        step(1, 6'd7, 0, 0);
        step(1, 6'd9, 0, 0);
        step(0, 6'd0, 0, 0);
        check("pre_rst_count", count, 3);
        check("pre_rst_buffer", buffer, 18'h00005);
        hit_reset();

        // window advance with display idle
        step(1, 6'd5, 0, 0);
        step(1, 6'd7, 0, 0);
        step(1, 6'd9, 0, 0);
        step(0, 6'd0, 1, 0);
        step(0, 6'd0, 0, 0);
        check("t2_buffer", buffer, 18'h00147);
        check("t2_fu", frame_update, 1);
        step(0, 6'd0, 0, 0);
        check("t2_fu_once", frame_update, 0);

        // frame hold during vsync
        step(0, 6'd0, 1, 1);
        step(0, 6'd0, 1, 1);
        step(0, 6'd0, 0, 1);
        check("t3_hold", buffer, 18'h00147);
        check("t3_no_fu", frame_update, 0);
        step(0, 6'd0, 0, 0);
        check("t3_release", buffer, win(6'd7, 6'd9, 6'd0));
        check("t3_fu", frame_update, 1);

        // full FIFO, refused push, same-edge push/pop
        step(1, 6'd1, 0, 0);
        step(1, 6'd2, 0, 0);
        step(1, 6'd3, 0, 0);
        step(1, 6'd4, 0, 0);
        check("t4_full_count", count, 4);
        check("t4_full_ready", in_ready, 0);
        step(1, 6'd5, 0, 0);
        check("t4_refused", count, 4);
        step(1, 6'd6, 1, 0);
        check("t4_adv_full", count, 3);
        step(1, 6'd6, 0, 0);
        check("t4_refill", count, 4);
        step(0, 6'd0, 0, 0);
        check("t4_window", buffer, win(6'd9, 6'd1, 6'd2));
        step(0, 6'd0, 1, 0);
        step(1, 6'd9, 1, 0);
        check("t4_pushpop", count, 3);
        step(0, 6'd0, 1, 0);
        step(0, 6'd0, 1, 0);
        step(0, 6'd0, 0, 0);
        check("t4_order", buffer, win(6'd4, 6'd6, 6'd9));
        step(0, 6'd0, 1, 0);

        // underrun on empty FIFO
        step(0, 6'd0, 1, 0);
        step(0, 6'd0, 0, 0);
        check("t5_window", buffer, win(6'd9, 6'd0, 6'd0));
        check("t5_underrun", underrun, 1);
        step(1, 6'd3, 1, 0);
        check("t5_nobypass", count, 1);
        step(0, 6'd0, 1, 0);
        step(1, 6'd0, 0, 0);
        check("t5_sticky", underrun, 1);

        // random traffic against the model
        hit_reset();
        vs_r = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 4) == 0) vs_r = ~vs_r;
            step(1'($urandom_range(0, 1)),
                 NOTE_W'($urandom_range(0, 63)),
                 ($urandom_range(0, 9) < 3),
                 vs_r);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
